rd_param: RTL and testbench
===========================

Name: rd_param

Overview:
Parametrised sequential restoring divider, successor to the fixed 8-bit rd block.
- Width is generic; signed/unsigned mode is selected per operation; divide-by-zero and signed-overflow are flagged.
- Retires one quotient bit per clock with constant latency and a start/done pulse handshake.
- Sits behind datapath control logic that issues a start pulse and waits for done.

Parameters:
W, 8, operand and result width in bits (W >= 2)
CW, $clog2(W+1), iteration counter width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset; clears all state when 0
start  input  1  request pulse; sampled only when idle
x  input  W  dividend; two's complement when signed_mode=1
y  input  W  divisor; two's complement when signed_mode=1
signed_mode  input  1  1 = signed division, 0 = unsigned; sampled with start
quotient  output  W  result quotient; held until next completion
remainder  output  W  result remainder; held until next completion
done  output  1  one-cycle pulse marking new quotient/remainder
busy  output  1  high while an operation is in flight
div_by_zero  output  1  y was 0 for the completed operation; valid with results
overflow  output  1  signed -2^(W-1) / -1 for the completed operation; valid with results

Behaviour:
- Reset (reset=0, any time, asynchronous): state=IDLE; quotient, remainder, all flags and done = 0; counter = 0. An operation in flight is abandoned and never signals done.
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 at edge E0 captures x, y and signed_mode.
  - In signed mode, operand magnitudes are captured (|x|, |y| as W-bit unsigned; |-2^(W-1)| = 2^(W-1)), and the sign of x and the sign of x XOR y are stored.
  - Partial remainder is cleared, counter is loaded with W, and the state moves to CALC.
- CALC, one iteration per edge:
  - Shift {rem, dvd} left by 1.
  - trial = rem - divisor, computed in W+1 bits.
  - If trial >= 0: rem = trial and the quotient bit is 1. Otherwise rem is restored and the quotient bit is 0.
  - The counter decrements. After the W-th iteration (edge E0+W) the state moves to FIX.
- FIX, at edge E0+W+1:
  - Signed mode: negate the quotient if the sign XOR is 1; negate the remainder if x was negative. This gives truncation toward zero, with the remainder sign following the dividend.
  - Register quotient, remainder and flags. done=1 for exactly one cycle. State returns to IDLE.
- Latency: done is high in the cycle following edge E0+W+1 (W+1 clocks after start is sampled). Latency is constant for every operand pair.
- busy = (state != IDLE). It is combinational from state and is 0 during the done cycle.
- start while busy is ignored and has no effect on the operation in flight.
- start during the done cycle is accepted, so back-to-back operations are possible.
- Divide by zero (y==0):
  - The full latency still runs.
  - quotient = all ones, remainder = x (the original x, in both modes), div_by_zero = 1.
- Signed overflow (x = -2^(W-1), y = -1, signed_mode=1):
  - quotient = 2^(W-1), wrapped to -2^(W-1); remainder = 0; overflow = 1.
- Flags are cleared at the next accepted start and are valid only alongside or after done.
- All arithmetic is W-bit modulo except the W+1-bit trial subtraction.

Decomposition:
- Shared package/header: state encodings (IDLE, CALC, FIX) and a shared W default localparam.
- One sub-module, rd_step: a purely combinational single restoring iteration.
  - Inputs: rem, dvd MSB, divisor.
  - Outputs: next rem, quotient bit.
  - The top-level instantiates it once and iterates it sequentially.

Test Plan:
- W=8, unsigned, x=8, y=16, start pulse -> after 9 clocks done pulse; q=0, r=8, flags 0, busy low.
- W=8, unsigned, x=200, y=7 -> q=28, r=4; then a second start in the done cycle with x=255, y=1 -> q=255, r=0, with no idle gap.
- W=8, signed, x=-7 (0xF9), y=2 -> q=-3 (0xFD), r=-1 (0xFF); then x=7, y=-2 -> q=0xFD, r=1.
- W=8, signed, x=0x80, y=0xFF -> q=0x80, r=0, overflow=1; then unsigned x=37, y=0 -> q=0xFF, r=37, div_by_zero=1, overflow=0.
- W=8: start with x=100, y=3; pulse start again mid-CALC -> ignored, result q=33, r=1. Start a new operation, drop reset to 0 at clock 4 -> all outputs 0 immediately, no done pulse; after reset release, x=9, y=4 gives q=2, r=1.
- W=16, unsigned, x=65535, y=255 -> done after 17 clocks, q=257, r=0.

Source files
------------

// File: rtl/rd_param_pkg.sv
// rtl/rd_param_pkg.sv - shared state encoding and default width for the rd_param divider
package rd_param_pkg;

  // Default operand/result width.
  localparam int RD_W_DEFAULT = 8;

  // Controller states: waiting for start, iterating quotient bits, sign fix-up/result register.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } rd_state_t;

endpackage

// File: rtl/rd_param_step.sv
// rtl/rd_param_step.sv - one combinational restoring-division iteration (module rd_step)
//
// Ports:
//   rem      in  W  current partial remainder (always < divisor)
//   dvd_msb  in  1  dividend bit shifted into the remainder this iteration
//   divisor  in  W  unsigned divisor magnitude
//   rem_next out W  partial remainder after the trial subtraction / restore
//   q_bit    out 1  quotient bit retired by this iteration
module rd_step
  import rd_param_pkg::*;
#(
  parameter int W = RD_W_DEFAULT
) (
  input  logic [W-1:0] rem,
  input  logic         dvd_msb,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);

  logic [W:0] shifted;
  logic [W:0] trial;

  assign shifted = {rem, dvd_msb};
  assign trial   = shifted - {1'b0, divisor};

  // When the shifted remainder reaches 2^W it always exceeds the W-bit divisor;
  // otherwise both operands fit in W bits and trial[W] is a true sign bit.
  assign q_bit    = shifted[W] | ~trial[W];
  // On restore shifted[W] is necessarily 0, so the low W bits are the whole value.
  assign rem_next = q_bit ? trial[W-1:0] : shifted[W-1:0];

endmodule

// File: rtl/rd_param.sv
// rtl/rd_param.sv - parametrised sequential restoring divider, one quotient bit per clock
//
// Ports:
//   clk          in  1  rising-edge clock
//   reset        in  1  asynchronous active-low reset
//   start        in  1  request pulse, sampled only when idle
//   x            in  W  dividend (two's complement when signed_mode=1)
//   y            in  W  divisor  (two's complement when signed_mode=1)
//   signed_mode  in  1  1 = signed division, sampled with start
//   quotient     out W  result quotient, held until next completion
//   remainder    out W  result remainder, held until next completion
//   done         out 1  one-cycle pulse marking new results
//   busy         out 1  operation in flight
//   div_by_zero  out 1  completed operation had y == 0
//   overflow     out 1  completed operation was signed -2^(W-1) / -1
module rd_param
  import rd_param_pkg::*;
#(
  parameter int W = RD_W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         signed_mode,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         done,
  output logic         busy,
  output logic         div_by_zero,
  output logic         overflow
);

  localparam int CW = $clog2(W + 1);

  rd_state_t     state;
  rd_state_t     state_next;
  logic [CW-1:0] cnt;
  logic [W-1:0]  rem_q;
  logic [W-1:0]  dvd_q;    // dividend magnitude; quotient bits shift in from the LSB
  logic [W-1:0]  dvs_q;    // divisor magnitude
  logic [W-1:0]  x_q;      // original dividend, returned as remainder on divide by zero
  logic          neg_q;
  logic          neg_r;
  logic          dbz_q;
  logic          ovf_q;
  logic [W-1:0]  rem_next;
  logic          q_bit;

  rd_step #(.W(W)) u_step (
    .rem      (rem_q),
    .dvd_msb  (dvd_q[W-1]),
    .divisor  (dvs_q),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (cnt == CW'(1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      x_q         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x_q         <= x;
            rem_q       <= '0;
            cnt         <= CW'(W);
            // Negating -2^(W-1) wraps to itself, which is the correct unsigned magnitude.
            dvd_q       <= (signed_mode && x[W-1]) ? -x : x;
            dvs_q       <= (signed_mode && y[W-1]) ? -y : y;
            neg_q       <= signed_mode & (x[W-1] ^ y[W-1]);
            neg_r       <= signed_mode & x[W-1];
            dbz_q       <= (y == '0);
            ovf_q       <= signed_mode && (x == {1'b1, {(W-1){1'b0}}}) && (y == '1);
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
        end
        CALC: begin
          rem_q <= rem_next;
          dvd_q <= {dvd_q[W-2:0], q_bit};
          cnt   <= cnt - CW'(1);
        end
        FIX: begin
          if (dbz_q) begin
            quotient  <= '1;
            remainder <= x_q;
          end else begin
            quotient  <= neg_q ? -dvd_q : dvd_q;
            remainder <= neg_r ? -rem_q : rem_q;
          end
          div_by_zero <= dbz_q;
          overflow    <= ovf_q;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rd_param.sv
// tb/tb_rd_param.sv - self-checking bench for rd_param with a behavioural division model
`timescale 1ns/1ps
module tb_rd_param;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
  } res_t;

  // Division result by plain integer arithmetic (SV division truncates toward zero).
  function automatic res_t ref_div(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input bit sm);
    res_t o;
    longint mask, half, ua, ub, sa, sb, qq, rr;
    mask  = (longint'(1) << w) - 1;
    half  = longint'(1) << (w - 1);
    ua    = longint'(a) & mask;
    ub    = longint'(b) & mask;
    o.dbz = (ub == 0);
    o.ovf = 1'b0;
    if (ub == 0) begin
      qq = mask;
      rr = ua;
    end else if (!sm) begin
      qq = ua / ub;
      rr = ua % ub;
    end else begin
      sa    = (ua >= half) ? ua - 2 * half : ua;
      sb    = (ub >= half) ? ub - 2 * half : ub;
      qq    = sa / sb;
      rr    = sa % sb;
      o.ovf = (sa == -half) && (sb == -1);
    end
    o.q = 32'(qq & mask);
    o.r = 32'(rr & mask);
    return o;
  endfunction

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  x = '0;
  logic [7:0]  y = '0;
  logic        signed_mode = 1'b0;
  logic [7:0]  quotient, remainder;
  logic        done, busy, div_by_zero, overflow;

  logic        start16 = 1'b0;
  logic [15:0] x16 = '0;
  logic [15:0] y16 = '0;
  logic        sm16 = 1'b0;
  logic [15:0] q16, r16;
  logic        done16, busy16, dbz16, ovf16;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  rd_param #(.W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .x(x), .y(y), .signed_mode(signed_mode),
    .quotient(quotient), .remainder(remainder), .done(done), .busy(busy),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  rd_param #(.W(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .x(x16), .y(y16), .signed_mode(sm16),
    .quotient(q16), .remainder(r16), .done(done16), .busy(busy16),
    .div_by_zero(dbz16), .overflow(ovf16)
  );

  // Transaction-level model of the 8-bit unit: an accepted start completes
  // W+1 = 9 clocks later; results and flags change only then, flags clear on accept.
  int         m_left = 0;
  logic       m_done = 1'b0;
  logic [7:0] m_q = '0;
  logic [7:0] m_r = '0;
  logic       m_dbz = 1'b0;
  logic       m_ovf = 1'b0;
  res_t       pend;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_q    <= '0;
      m_r    <= '0;
      m_dbz  <= 1'b0;
      m_ovf  <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left == 0) begin
        if (start) begin
          m_left <= 9;
          pend   <= ref_div(8, 32'(x), 32'(y), signed_mode);
          m_dbz  <= 1'b0;
          m_ovf  <= 1'b0;
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1;
          m_q    <= pend.q[7:0];
          m_r    <= pend.r[7:0];
          m_dbz  <= pend.dbz;
          m_ovf  <= pend.ovf;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({busy, done, div_by_zero, overflow, quotient, remainder} !==
          {(m_left != 0), m_done, m_dbz, m_ovf, m_q, m_r}) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t actual busy=%0b done=%0b dbz=%0b ovf=%0b q=%02h r=%02h required busy=%0b done=%0b dbz=%0b ovf=%0b q=%02h r=%02h",
                 $time, busy, done, div_by_zero, overflow, quotient, remainder,
                 (m_left != 0), m_done, m_dbz, m_ovf, m_q, m_r);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [7:0] a, input logic [7:0] b, input bit s);
    x = a;
    y = b;
    signed_mode = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Returns the number of rising edges after the start edge before done is seen.
  task automatic wait_done(input string name, output int lat);
    lat = -1;
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout waiting for done", name);
    end
  endtask

  task automatic expect_res(input string name, input logic [7:0] q, input logic [7:0] r,
                            input bit dbz, input bit ovf);
    check({name, "_q"}, 32'(quotient), 32'(q));
    check({name, "_r"}, 32'(remainder), 32'(r));
    check({name, "_flags"}, {30'd0, div_by_zero, overflow}, {30'd0, dbz, ovf});
  endtask

  initial begin
    res_t p;
    int   lat;
    int   seen;

    #2 reset = 1'b0;
    #1;
    check("reset_outputs", {quotient, remainder, 4'(0), done, busy, div_by_zero, overflow}, 32'd0);
    check("reset_outputs16", {q16, r16}, 32'd0);

    // Model pinned against hand-computed values.
    p = ref_div(8, 32'hF9, 32'h02, 1'b1);
    check("model_neg7_div2", {p.q[7:0], p.r[7:0]}, {16'd0, 16'hFDFF});
    p = ref_div(8, 32'h80, 32'hFF, 1'b1);
    check("model_ovf", {p.q[7:0], p.r[7:0], 14'd0, p.dbz, p.ovf}, {8'h80, 8'h00, 16'h0001});
    p = ref_div(8, 32'd37, 32'd0, 1'b0);
    check("model_dbz", {p.q[7:0], p.r[7:0], 14'd0, p.dbz, p.ovf}, {8'hFF, 8'd37, 16'h0002});
    p = ref_div(16, 32'd65535, 32'd255, 1'b0);
    check("model_w16", {p.q[15:0], p.r[15:0]}, {16'd257, 16'd0});

    @(posedge clk);
    #1 reset = 1'b1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;

    launch(8'd8, 8'd16, 1'b0);
    wait_done("t1", lat);
    check("t1_latency", 32'(lat), 32'd9);
    check("t1_busy", 32'(busy), 32'd0);
    expect_res("t1", 8'd0, 8'd8, 1'b0, 1'b0);

    @(posedge clk);
    #1;
    launch(8'd200, 8'd7, 1'b0);
    wait_done("t2a", lat);
    expect_res("t2a", 8'd28, 8'd4, 1'b0, 1'b0);
    launch(8'd255, 8'd1, 1'b0);
    wait_done("t2b", lat);
    check("t2b_b2b_latency", 32'(lat), 32'd9);
    expect_res("t2b", 8'd255, 8'd0, 1'b0, 1'b0);

    launch(8'hF9, 8'd2, 1'b1);
    wait_done("t3a", lat);
    expect_res("t3a", 8'hFD, 8'hFF, 1'b0, 1'b0);
    launch(8'd7, 8'hFE, 1'b1);
    wait_done("t3b", lat);
    expect_res("t3b", 8'hFD, 8'h01, 1'b0, 1'b0);

    launch(8'h80, 8'hFF, 1'b1);
    wait_done("t4a", lat);
    expect_res("t4a", 8'h80, 8'h00, 1'b0, 1'b1);
    launch(8'd37, 8'd0, 1'b0);
    wait_done("t4b", lat);
    expect_res("t4b", 8'hFF, 8'd37, 1'b1, 1'b0);

    @(posedge clk);
    #1;
    launch(8'd100, 8'd3, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    x = 8'd5;
    y = 8'd5;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("t5", lat);
    expect_res("t5", 8'd33, 8'd1, 1'b0, 1'b0);

    @(posedge clk);
    #1;
    launch(8'd50, 8'd6, 1'b0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_reset_outputs", {quotient, remainder, 12'd0, done, busy, div_by_zero, overflow},
          32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("abandoned_no_done", 32'(seen), 32'd0);
    @(posedge clk);
    #1;
    launch(8'd9, 8'd4, 1'b0);
    wait_done("t6", lat);
    expect_res("t6", 8'd2, 8'd1, 1'b0, 1'b0);

    @(posedge clk);
    #1;
    x16 = 16'd65535;
    y16 = 16'd255;
    sm16 = 1'b0;
    start16 = 1'b1;
    @(posedge clk);
    #1 start16 = 1'b0;
    lat = -1;
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk);
      if (done16) begin
        lat = i;
        break;
      end
    end
    check("w16_latency", 32'(lat), 32'd17);
    check("w16_result", {q16, r16}, {16'd257, 16'd0});
    check("w16_flags", {30'd0, dbz16, ovf16}, 32'd0);

    for (int n = 0; n < 300; n++) begin
      logic [7:0] a, b;
      bit s;
      a = 8'($urandom);
      b = 8'($urandom);
      s = 1'($urandom);
      case ($urandom_range(7))
        0: b = 8'd0;
        1: begin a = 8'h80; b = 8'hFF; end
        2: b = 8'd1;
        default: ;
      endcase
      launch(a, b, s);
      if ($urandom_range(3) == 0) begin
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1;
        x = 8'($urandom);
        y = 8'($urandom);
        signed_mode = 1'($urandom);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
      wait_done("rand", lat);
      if ($urandom_range(1) == 0) begin
        @(posedge clk);
        #1;
        repeat ($urandom_range(2)) @(posedge clk);
        #1;
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
